// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ single-word requesters into one FIFO write port, in bursts of up to MAX_BURST beats.
// Latency: one cycle from IDLE to the first grant; bursts chain to the next owner with no bubble; ack/fifo_wr are combinational.
// Backpressure: fifo_full stalls the owner's burst in place, with no timeout; no write is ever issued while full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic                          owner_valid,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  owner_nxt, last_owner, last_owner_nxt;
  logic [IDW-1:0]  rr_base, winner;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            any_req, found, beat, burst_end;
  logic [DATA_WIDTH-1:0] owner_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner_id   <= '0;
      last_owner <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner_id   <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Outputs are gated by reset_n so a reset landing mid-burst transfers nothing.
  always_comb begin
    beat      = reset_n && (state == GRANT) && req[owner_id] && !fifo_full;
    burst_end = (state == GRANT) &&
                (!req[owner_id] || (beat && (beat_cnt == CW'(MAX_BURST - 1))));
    // At burst end the pointer moves to the finishing owner in the same edge.
    rr_base   = burst_end ? owner_id : last_owner;
    any_req   = |req;

    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[rr_base + IDW'(i + 1)]) begin
        winner = rr_base + IDW'(i + 1);
        found  = 1'b1;
      end
    end

    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_id == IDW'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    state_nxt      = state;
    owner_nxt      = owner_id;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt    = GRANT;
          owner_nxt    = winner;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (burst_end) begin
          last_owner_nxt = owner_id;
          beat_cnt_nxt   = '0;
          if (any_req) owner_nxt = winner;
          else         state_nxt = IDLE;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    ack         = beat ? (NUM_REQ'(1) << owner_id) : '0;
    fifo_wr     = beat;
    owner_valid = reset_n && (state == GRANT);
    fifo_w_data = owner_valid ? owner_data : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios push expected writes into a scoreboard that a negedge monitor drains.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [7:0]  fifo_w_data;
  logic        owner_valid;
  logic [1:0]  owner_id;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .ack(ack), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data),
    .owner_valid(owner_valid), .owner_id(owner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Requester model: words left to send and the next word index per requester.
  int left [4];
  int word [4];

  // Scoreboard entry: {fifo_wr, owner_id, ack, data}
  logic [14:0] sb_q[$];
  logic [14:0] exp_e, act_e;

  logic [3:0] s_ack;
  logic       s_wr, s_valid;
  logic [1:0] s_owner;
  logic [2:0] s_bc;
  logic [7:0] s_data;
  int cyc_n, first_wr, last_wr, n_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic void push(input int r, input int w);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    sb_q.push_back({1'b1, 2'(r), oh, 4'(r), 4'(w)});
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = (left[i] != 0);
      req_data[i*8 +: 8] = {4'(i), 4'(word[i])};
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < 4; i++) if (left[i] != 0) p = 1;
    return p;
  endfunction

  // One clock: sample at negedge, then update the requester model just after the edge.
  task automatic cyc();
    @(negedge clk);
    s_ack   = ack;
    s_wr    = fifo_wr;
    s_valid = owner_valid;
    s_owner = owner_id;
    s_bc    = dut.beat_cnt;
    s_data  = fifo_w_data;
    cyc_n++;
    if (fifo_wr) begin
      if (first_wr < 0) first_wr = cyc_n;
      last_wr = cyc_n;
      n_wr++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (s_ack[i] && left[i] > 0) begin
        left[i]--;
        word[i]++;
      end
    end
    drive();
  endtask

  task automatic clear_trk();
    first_wr = -1;
    last_wr  = -1;
    n_wr     = 0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      word[i] = 0;
    end
  endtask

  task automatic do_reset();
    clear_trk();
    drive();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic finish_scen(input string name, input int exp_wr, input int exp_span);
    for (int k = 0; k < 200 && pending(); k++) cyc();
    repeat (2) cyc();
    chk({name, "_done"}, {31'd0, pending()}, 32'd0);
    chk({name, "_sb_empty"}, sb_q.size(), 32'd0);
    chk({name, "_nwr"}, n_wr, exp_wr);
    chk({name, "_span"}, last_wr - first_wr + 1, exp_span);
  endtask

  always @(negedge clk) begin
    if (fifo_wr || ack != 4'b0000) begin
      act_e = {fifo_wr, owner_id, ack, fifo_w_data};
      n_chk++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_write actual=%0h required=none", act_e);
      end else begin
        exp_e = sb_q.pop_front();
        if (act_e === exp_e) n_pass++;
        else $display("FAIL write_seq actual=%0h required=%0h", act_e, exp_e);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    cyc_n     = 0;
    clear_trk();
    drive();

    // Reset with all requesting, one word each.
    for (int i = 0; i < 4; i++) left[i] = 1;
    drive();
    push(0, 0); push(1, 0); push(2, 0); push(3, 0);
    repeat (2) begin
      cyc();
      chk("rst_ack", s_ack, 0);
      chk("rst_wr", s_wr, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_data", s_data, 0);
    end
    reset_n = 1'b1;
    cyc();
    chk("post_rst_ack", s_ack, 0);
    chk("post_rst_valid", s_valid, 0);
    cyc();
    chk("first_owner", s_owner, 0);
    chk("first_ack", s_ack, 4'b0001);
    finish_scen("rst", 4, 7);

    // Lone requester 1: continuous re-grants.
    do_reset();
    left[1] = 8;
    drive();
    for (int w = 0; w < 8; w++) push(1, w);
    finish_scen("lone", 8, 8);

    // All requesting: bursts of four in round-robin order, no gaps.
    do_reset();
    for (int i = 0; i < 4; i++) left[i] = 8;
    drive();
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < 4; b++) push(r, rnd*4 + b);
    finish_scen("all", 32, 32);

    // Backpressure after owner 0's 2nd beat.
    do_reset();
    left[0] = 6;
    left[1] = 2;
    drive();
    push(0, 0); push(0, 1); push(0, 2); push(0, 3);
    push(1, 0); push(1, 1); push(0, 4); push(0, 5);
    repeat (3) cyc();
    fifo_full = 1'b1;
    repeat (3) begin
      cyc();
      chk("bp_wr", s_wr, 0);
      chk("bp_ack", s_ack, 0);
      chk("bp_owner", s_owner, 0);
      chk("bp_beat_cnt", s_bc, 2);
    end
    fifo_full = 1'b0;
    finish_scen("bp", 8, 12);

    // Owner 0 releases after two beats; requester 2 takes over.
    do_reset();
    left[0] = 2;
    left[2] = 3;
    drive();
    push(0, 0); push(0, 1); push(2, 0); push(2, 1); push(2, 2);
    repeat (3) cyc();
    cyc();
    chk("rel_gap_ack", s_ack, 0);
    cyc();
    chk("rel_owner", s_owner, 2);
    chk("rel_beat_cnt", s_bc, 0);
    chk("rel_ack", s_ack, 4'b0100);
    finish_scen("rel", 5, 6);

    // Reset during owner 3's 2nd beat with requester 0 also pending.
    do_reset();
    left[3] = 4;
    drive();
    push(3, 0); push(0, 0); push(0, 1); push(3, 1); push(3, 2); push(3, 3);
    repeat (2) cyc();
    reset_n = 1'b0;
    left[0] = 2;
    drive();
    cyc();
    chk("mid_rst_ack", s_ack, 0);
    chk("mid_rst_wr", s_wr, 0);
    reset_n = 1'b1;
    cyc();
    chk("mid_post_ack", s_ack, 0);
    chk("mid_post_valid", s_valid, 0);
    cyc();
    chk("mid_owner", s_owner, 0);
    chk("mid_ack", s_ack, 4'b0001);
    finish_scen("mid", 6, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
